// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, selectable
// read-during-write behaviour, optional output stage and clear sweep.
module dpram_be_clr #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    busy_o,
    input  logic                    en_a_i,
    input  logic                    we_a_i,
    input  logic [DATA_WIDTH/8-1:0] be_a_i,
    input  logic [ADDR_WIDTH-1:0]   addr_a_i,
    input  logic [DATA_WIDTH-1:0]   data_a_i,
    output logic [DATA_WIDTH-1:0]   data_a_o,
    output logic                    valid_a_o,
    input  logic                    en_b_i,
    input  logic                    we_b_i,
    input  logic [DATA_WIDTH/8-1:0] be_b_i,
    input  logic [ADDR_WIDTH-1:0]   addr_b_i,
    input  logic [DATA_WIDTH-1:0]   data_b_i,
    output logic [DATA_WIDTH-1:0]   data_b_o,
    output logic                    valid_b_o
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    busy_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    sweep_we;
    logic                    acc;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    rd_a;
    logic                    rd_b;
    logic                    wr_a;
    logic                    wr_b;
    logic [DATA_WIDTH-1:0]   old_a;
    logic [DATA_WIDTH-1:0]   old_b;
    logic [DATA_WIDTH-1:0]   rdw_a;
    logic [DATA_WIDTH-1:0]   rdw_b;

    logic [DATA_WIDTH-1:0]   q1_a;
    logic [DATA_WIDTH-1:0]   q1_b;
    logic                    v1_a;
    logic                    v1_b;

    // State register, registered busy flag and sweep address counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_CLEAR);
            if (sweep_we) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next state: leave CLEAR once the last word has been written
    always_comb begin
        state_d = state_q;
        if (state_q == S_CLEAR && cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = S_READY;
        end
    end

    // FSM outputs: sweep write strobe and port access gate
    always_comb begin
        sweep_we = (state_q == S_CLEAR);
        acc      = (state_q == S_READY) && !rst_i;
        busy_o   = busy_q;
    end

    assign rd_a  = acc && en_a_i;
    assign rd_b  = acc && en_b_i;
    assign wr_a  = rd_a && we_a_i;
    assign wr_b  = rd_b && we_b_i;
    assign old_a = mem[addr_a_i];
    assign old_b = mem[addr_b_i];

    // Array update; A is applied after B so A owns contested lanes
    always_ff @(posedge clk_i) begin
        if (sweep_we) begin
            mem[cnt_q] <= INIT_VALUE;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_b && be_b_i[k]) begin
                    mem[addr_b_i][8*k +: 8] <= data_b_i[8*k +: 8];
                end
                if (wr_a && be_a_i[k]) begin
                    mem[addr_a_i][8*k +: 8] <= data_a_i[8*k +: 8];
                end
            end
        end
    end

    // Same-port read-during-write merge; other port always sees old data
    always_comb begin
        rdw_a = old_a;
        rdw_b = old_b;
        for (int k = 0; k < LANES; k++) begin
            if (RDW_MODE == 0 && wr_a && be_a_i[k]) begin
                rdw_a[8*k +: 8] = data_a_i[8*k +: 8];
            end
            if (RDW_MODE == 0 && wr_b && be_b_i[k]) begin
                rdw_b[8*k +: 8] = data_b_i[8*k +: 8];
            end
        end
    end

    // First read stage; data holds between accesses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q1_a <= '0;
            q1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
        end else begin
            v1_a <= rd_a;
            v1_b <= rd_b;
            if (rd_a) begin
                q1_a <= rdw_a;
            end
            if (rd_b) begin
                q1_b <= rdw_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2_a;
            logic [DATA_WIDTH-1:0] q2_b;
            logic                  v2_a;
            logic                  v2_b;

            // Second read stage, a plain copy of the first
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q2_a <= '0;
                    q2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) begin
                        q2_a <= q1_a;
                    end
                    if (v1_b) begin
                        q2_b <= q1_b;
                    end
                end
            end

            assign data_a_o  = q2_a;
            assign data_b_o  = q2_b;
            assign valid_a_o = v2_a;
            assign valid_b_o = v2_b;
        end else begin : g_no_out_reg
            assign data_a_o  = q1_a;
            assign data_b_o  = q1_b;
            assign valid_a_o = v1_a;
            assign valid_b_o = v1_b;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_be_clr.sv
// Testbench for dpram_be_clr: two instances share stimulus,
// one new-data/latency-1, one old-data/latency-2.
module tb_dpram_be_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, we_a, en_b, we_b;
    logic [1:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;

    logic        busy0, busy1;
    logic [15:0] q0a, q0b, q1a, q1b;
    logic        v0a, v0b, v1a, v1b;

    int checks = 0;
    int passes = 0;

    logic [15:0] m [16];
    logic [15:0] eq0a, eq0b, eq1a, eq1b, pq1a, pq1b;
    logic        ev0a, ev0b, ev1a, ev1b, pv1a, pv1b;

    always #5 clk = ~clk;

    dpram_be_clr #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0),
        .OUT_REG(0), .INIT_VALUE(16'hA5A5)
    ) u0 (
        .clk_i(clk), .rst_i(rst), .busy_o(busy0),
        .en_a_i(en_a), .we_a_i(we_a), .be_a_i(be_a),
        .addr_a_i(addr_a), .data_a_i(din_a),
        .data_a_o(q0a), .valid_a_o(v0a),
        .en_b_i(en_b), .we_b_i(we_b), .be_b_i(be_b),
        .addr_b_i(addr_b), .data_b_i(din_b),
        .data_b_o(q0b), .valid_b_o(v0b)
    );

    dpram_be_clr #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1),
        .OUT_REG(1), .INIT_VALUE(16'hA5A5)
    ) u1 (
        .clk_i(clk), .rst_i(rst), .busy_o(busy1),
        .en_a_i(en_a), .we_a_i(we_a), .be_a_i(be_a),
        .addr_a_i(addr_a), .data_a_i(din_a),
        .data_a_o(q1a), .valid_a_o(v1a),
        .en_b_i(en_b), .we_b_i(we_b), .be_b_i(be_b),
        .addr_b_i(addr_b), .data_b_i(din_b),
        .data_b_o(q1b), .valid_b_o(v1b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_a(input logic e, input logic w, input logic [1:0] b,
                         input logic [3:0] ad, input logic [15:0] d);
        en_a = e; we_a = w; be_a = b; addr_a = ad; din_a = d;
    endtask

    task automatic set_b(input logic e, input logic w, input logic [1:0] b,
                         input logic [3:0] ad, input logic [15:0] d);
        en_b = e; we_b = w; be_b = b; addr_b = ad; din_b = d;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
        set_b(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o,
                                          input logic [15:0] d,
                                          input logic [1:0] b);
        logic [15:0] r;
        r = o;
        if (b[0]) r[7:0]  = d[7:0];
        if (b[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic test_reset();
        int n;
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1)
            $display("FAIL rst_busy got %b%b exp 11", busy0, busy1);
        else passes++;
        checks++;
        if ({v0a, v0b, v1a, v1b} !== 4'b0)
            $display("FAIL rst_valid got %b exp 0000", {v0a, v0b, v1a, v1b});
        else passes++;
        checks++;
        if ({q0a, q0b, q1a, q1b} !== 64'h0)
            $display("FAIL rst_data got %h exp 0", {q0a, q0b, q1a, q1b});
        else passes++;
        rst = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) $display("FAIL sweep_len got %0d exp 16", n);
        else passes++;
        checks++;
        if (busy1 !== 1'b0) $display("FAIL sweep_busy1 got %b exp 0", busy1);
        else passes++;
    endtask

    task automatic test_sweep_read();
        for (int i = 0; i <= 16; i++) begin
            set_a(i < 16, 1'b0, 2'b00, 4'(i), 16'h0);
            tick();
            checks++;
            if (i < 16) begin
                if (v0a !== 1'b1 || q0a !== 16'hA5A5)
                    $display("FAIL t1_u0 addr %0d got v=%b d=%h exp v=1 d=a5a5", i, v0a, q0a);
                else passes++;
            end else begin
                if (v0a !== 1'b0) $display("FAIL t1_u0_end got v=%b exp 0", v0a);
                else passes++;
            end
            checks++;
            if (i == 0) begin
                if (v1a !== 1'b0) $display("FAIL t1_u1_lat got v=%b exp 0", v1a);
                else passes++;
            end else begin
                if (v1a !== 1'b1 || q1a !== 16'hA5A5)
                    $display("FAIL t1_u1 addr %0d got v=%b d=%h exp v=1 d=a5a5", i - 1, v1a, q1a);
                else passes++;
            end
        end
        idle();
    endtask

    task automatic test_byte_write();
        set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'h1234);
        tick();
        set_a(1'b1, 1'b1, 2'b10, 4'd3, 16'hFF00);
        tick();
        set_a(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
        checks++;
        if (v0b !== 1'b0) $display("FAIL t2_pre got v=%b exp 0", v0b);
        else passes++;
        set_b(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
        tick();
        checks++;
        if (v0b !== 1'b1 || q0b !== 16'hFF34 || v1b !== 1'b0)
            $display("FAIL t2_c1 got v0=%b d0=%h v1=%b exp 1 ff34 0", v0b, q0b, v1b);
        else passes++;
        idle();
        tick();
        checks++;
        if (v0b !== 1'b0 || q0b !== 16'hFF34)
            $display("FAIL t2_u0_hold got v=%b d=%h exp 0 ff34", v0b, q0b);
        else passes++;
        checks++;
        if (v1b !== 1'b1 || q1b !== 16'hFF34)
            $display("FAIL t2_u1 got v=%b d=%h exp 1 ff34", v1b, q1b);
        else passes++;
        tick();
        checks++;
        if (v1b !== 1'b0 || q1b !== 16'hFF34)
            $display("FAIL t2_u1_hold got v=%b d=%h exp 0 ff34", v1b, q1b);
        else passes++;
    endtask

    task automatic test_rdw();
        set_a(1'b1, 1'b1, 2'b11, 4'd5, 16'h0000);
        tick();
        set_a(1'b1, 1'b1, 2'b01, 4'd5, 16'hBEEF);
        set_b(1'b1, 1'b0, 2'b00, 4'd5, 16'h0);
        tick();
        checks++;
        if (q0a !== 16'h00EF) $display("FAIL t3_rdw_new got %h exp 00ef", q0a);
        else passes++;
        checks++;
        if (q0b !== 16'h0000) $display("FAIL t3_cross_u0 got %h exp 0000", q0b);
        else passes++;
        idle();
        tick();
        checks++;
        if (v1a !== 1'b1 || q1a !== 16'h0000)
            $display("FAIL t3_rdw_old got v=%b d=%h exp 1 0000", v1a, q1a);
        else passes++;
        checks++;
        if (q1b !== 16'h0000) $display("FAIL t3_cross_u1 got %h exp 0000", q1b);
        else passes++;
        set_b(1'b1, 1'b0, 2'b00, 4'd5, 16'h0);
        tick();
        checks++;
        if (q0b !== 16'h00EF) $display("FAIL t3_after_u0 got %h exp 00ef", q0b);
        else passes++;
        idle();
        tick();
        checks++;
        if (q1b !== 16'h00EF) $display("FAIL t3_after_u1 got %h exp 00ef", q1b);
        else passes++;
    endtask

    task automatic test_collision();
        set_a(1'b1, 1'b1, 2'b01, 4'd7, 16'h1111);
        set_b(1'b1, 1'b1, 2'b11, 4'd7, 16'h2222);
        tick();
        idle();
        set_a(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
        tick();
        checks++;
        if (q0a !== 16'h2211) $display("FAIL t4_mix_u0 got %h exp 2211", q0a);
        else passes++;
        idle();
        tick();
        checks++;
        if (q1a !== 16'h2211) $display("FAIL t4_mix_u1 got %h exp 2211", q1a);
        else passes++;
        set_a(1'b1, 1'b1, 2'b11, 4'd7, 16'h1111);
        set_b(1'b1, 1'b1, 2'b11, 4'd7, 16'h2222);
        tick();
        idle();
        set_b(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
        tick();
        checks++;
        if (q0b !== 16'h1111) $display("FAIL t4_awin_u0 got %h exp 1111", q0b);
        else passes++;
        idle();
        tick();
        checks++;
        if (q1b !== 16'h1111) $display("FAIL t4_awin_u1 got %h exp 1111", q1b);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy0 !== 1'b1 || v0a !== 1'b0 || q0a !== 16'h0)
            $display("FAIL t5_rst got b=%b v=%b d=%h exp 1 0 0000", busy0, v0a, q0a);
        else passes++;
        rst = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            if (n == 10) set_a(1'b1, 1'b1, 2'b11, 4'd2, 16'h1234);
            else idle();
            tick();
            n++;
            if (n == 11) begin
                checks++;
                if (v0a !== 1'b0 || q0a !== 16'h0)
                    $display("FAIL t5_busy_port got v=%b d=%h exp 0 0000", v0a, q0a);
                else passes++;
            end
        end
        idle();
        checks++;
        if (n != 16) $display("FAIL t5_sweep_len got %0d exp 16", n);
        else passes++;
        set_a(1'b1, 1'b0, 2'b00, 4'd2, 16'h0);
        set_b(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
        tick();
        checks++;
        if (q0a !== 16'hA5A5 || q0b !== 16'hA5A5)
            $display("FAIL t5_dropped_u0 got %h %h exp a5a5 a5a5", q0a, q0b);
        else passes++;
        idle();
        tick();
        checks++;
        if (q1a !== 16'hA5A5 || q1b !== 16'hA5A5)
            $display("FAIL t5_dropped_u1 got %h %h exp a5a5 a5a5", q1a, q1b);
        else passes++;
    endtask

    task automatic test_random();
        logic [15:0] old_a, old_b;
        int n;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) $display("FAIL t6_sweep_len got %0d exp 16", n);
        else passes++;
        for (int i = 0; i < 16; i++) m[i] = 16'hA5A5;
        eq0a = '0; eq0b = '0; eq1a = '0; eq1b = '0; pq1a = '0; pq1b = '0;
        ev0a = 0; ev0b = 0; ev1a = 0; ev1b = 0; pv1a = 0; pv1b = 0;
        for (int c = 0; c < 10000; c++) begin
            checks++;
            if (v0a !== ev0a || q0a !== eq0a)
                $display("FAIL t6_u0_a cyc %0d got %b %h exp %b %h", c, v0a, q0a, ev0a, eq0a);
            else passes++;
            checks++;
            if (v0b !== ev0b || q0b !== eq0b)
                $display("FAIL t6_u0_b cyc %0d got %b %h exp %b %h", c, v0b, q0b, ev0b, eq0b);
            else passes++;
            checks++;
            if (v1a !== ev1a || q1a !== eq1a)
                $display("FAIL t6_u1_a cyc %0d got %b %h exp %b %h", c, v1a, q1a, ev1a, eq1a);
            else passes++;
            checks++;
            if (v1b !== ev1b || q1b !== eq1b)
                $display("FAIL t6_u1_b cyc %0d got %b %h exp %b %h", c, v1b, q1b, ev1b, eq1b);
            else passes++;
            set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
            set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
            old_a = m[addr_a];
            old_b = m[addr_b];
            ev0a = en_a;
            if (en_a) eq0a = we_a ? merge(old_a, din_a, be_a) : old_a;
            ev0b = en_b;
            if (en_b) eq0b = we_b ? merge(old_b, din_b, be_b) : old_b;
            ev1a = pv1a;
            if (pv1a) eq1a = pq1a;
            ev1b = pv1b;
            if (pv1b) eq1b = pq1b;
            pv1a = en_a;
            if (en_a) pq1a = old_a;
            pv1b = en_b;
            if (en_b) pq1b = old_b;
            if (en_b && we_b) m[addr_b] = merge(m[addr_b], din_b, be_b);
            if (en_a && we_a) m[addr_a] = merge(m[addr_a], din_a, be_a);
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_sweep_read();
        test_byte_write();
        test_rdw();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
